// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Streams a block of words out of a 1-cycle-latency synchronous RAM.
//   A job is started in IDLE with a base address and a word count. The
//   block issues one RAM read per cycle while the issue credit allows it,
//   collects the returned words in a 2-entry FIFO and presents them on a
//   valid/ready stream in address order (addresses wrap modulo the depth).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start_i; zero-length start pulses done_o
//   READ  | issuing reads, one per cycle within credit
//   DRAIN | all reads issued; waiting for the last word to be accepted
//
// Ports
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   start_i       start request, sampled only in IDLE
//   base_addr_i   first word address
//   len_i         word count, 0..RAM_WORDS_SIZE
//   busy_o        high while not IDLE
//   done_o        one-cycle pulse at job end
//   ram_r_addr_o  RAM read address
//   ram_data_i    RAM read data, valid one cycle after the address
//   data_o        stream data (FIFO head)
//   valid_o       stream valid (FIFO not empty)
//   ready_i       stream ready
module ram_stream_reader #(
  parameter int RAM_WORDS_SIZE  = 256,
  parameter int RAM_WORDS_WIDTH = 32,
  localparam int AW             = $clog2(RAM_WORDS_SIZE)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [AW-1:0]              base_addr_i,
  input  logic [AW:0]                len_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [AW-1:0]              ram_r_addr_o,
  input  logic [RAM_WORDS_WIDTH-1:0] ram_data_i,
  output logic [RAM_WORDS_WIDTH-1:0] data_o,
  output logic                       valid_o,
  input  logic                       ready_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;         // next address to issue
  logic [AW-1:0]        last_addr_q, last_addr_d; // last issued address
  logic [AW:0]          iss_left_q, iss_left_d; // reads still to issue
  logic [AW:0]          out_left_q, out_left_d; // words still to be accepted
  logic                 inflight_q, inflight_d; // read issued last cycle
  logic                 done_q, done_d;

  logic [RAM_WORDS_WIDTH-1:0] fifo_q [2];
  logic                       wr_ptr_q, rd_ptr_q;
  logic [1:0]                 count_q, count_d;

  logic       push, pop, issue;
  logic [1:0] occ_eff;

  assign push = inflight_q;
  assign pop  = (count_q != 2'd0) && ready_i;

  // Occupancy the FIFO would have after this edge if nothing new were
  // issued: entries held plus the word arriving, minus the one leaving.
  // count_q + inflight_q never exceeds 3, so two bits suffice.
  assign occ_eff = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue   = (state_q == S_READ) && (occ_eff < 2'd2) && (iss_left_q != '0);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    iss_left_d  = iss_left_q;
    out_left_d  = out_left_q;
    inflight_d  = issue;
    done_d      = 1'b0;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            addr_d     = base_addr_i;
            iss_left_d = len_i;
            out_left_d = len_i;
            state_d    = S_READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d      = addr_q + AW'(1);
          last_addr_d = addr_q;
          iss_left_d  = iss_left_q - (AW+1)'(1);
          if (iss_left_q == (AW+1)'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
      end
      default: state_d = S_IDLE;
    endcase

    // Accepted words are counted in any active state; the final one can
    // only arrive in DRAIN since data trails its read by two edges.
    if (state_q != S_IDLE && pop) begin
      out_left_d = out_left_q - (AW+1)'(1);
      if (out_left_q == (AW+1)'(1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      iss_left_q  <= '0;
      out_left_q  <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      iss_left_q  <= iss_left_d;
      out_left_q  <= out_left_d;
      inflight_q  <= inflight_d;
      done_q      <= done_d;
      count_q     <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // The address is shown combinationally in the issuing cycle and held
  // at the last issued value otherwise.
  assign ram_r_addr_o = issue ? addr_q : last_addr_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign valid_o      = (count_q != 2'd0);
  assign data_o       = valid_o ? fifo_q[rd_ptr_q] : '0;

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter RAM_WORDS_SIZE, default 256, RAM depth in words (power of two, >=4).
REQ-002 SHALL have parameter RAM_WORDS_WIDTH, default 32, RAM word width in bits.
REQ-003 SHALL use AW = log2(RAM_WORDS_SIZE) for address widths.
REQ-004 SHALL use one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-005 SHALL have ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start request, sampled only in IDLE
- base_addr_i  in  AW  first word address
- len_i  in  AW+1  word count, 0..RAM_WORDS_SIZE
- busy_o  out  1  high while not IDLE
- done_o  out  1  one-cycle pulse at job end
- ram_r_addr_o  out  AW  RAM read address
- ram_data_i  in  RAM_WORDS_WIDTH  RAM read data, valid one cycle after address sampled
- data_o  out  RAM_WORDS_WIDTH  stream data
- valid_o  out  1  stream valid
- ready_i  in  1  stream ready

Function
REQ-006 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE.
REQ-007 IDLE: on start_i=1 and len_i!=0, latch base_addr_i and len_i, then go to READ; on start_i=1 and len_i=0, pulse done_o next cycle and stay IDLE.
REQ-008 SHALL ignore start_i, base_addr_i and len_i outside IDLE.
REQ-009 READ: issue one read per cycle while the issue credit allows it; drive ram_r_addr_o = current address; then increment the address modulo RAM_WORDS_SIZE, wrapping RAM_WORDS_SIZE-1 -> 0.
REQ-010 SHALL capture ram_data_i into the output FIFO on the edge one cycle after each issued read.
REQ-011 Output FIFO: 2 entries. Issue credit = (FIFO occupancy + reads in flight) < 2, counting entries popped in the same cycle. No word is ever dropped or duplicated.
REQ-012 SHALL go to DRAIN in the cycle after the last (len-th) read is issued.
REQ-013 DRAIN: issue no reads. When the last word is accepted (valid_o & ready_i), pulse done_o for one cycle and return to IDLE in that same edge.
REQ-014 Stream: valid_o = FIFO not empty; data_o = FIFO head. data_o and valid_o SHALL stay stable while valid_o=1 and ready_i=0.
REQ-015 Words SHALL be emitted in address order: base, base+1, ... (mod RAM_WORDS_SIZE), len words total.
REQ-016 Latency: with ready_i held high, valid_o first rises 2 cycles after the start edge, and after that the block sustains 1 word per cycle.
REQ-017 Backpressure: ready_i low for any duration SHALL stall issue within credit limits, with no loss.
REQ-018 len_i = RAM_WORDS_SIZE SHALL read every word exactly once, wrapping at the end.
REQ-019 ram_r_addr_o SHALL hold its last value when no read is issued.
REQ-020 busy_o SHALL be high from the edge after start acceptance until the edge on which done_o is asserted.

Reset
REQ-021 rst_i=1 SHALL force IDLE, empty the FIFO, clear in-flight tracking, and set busy_o=0, done_o=0, valid_o=0, ram_r_addr_o=0, data_o=0.
REQ-022 Reset mid-job SHALL abort the job with no done_o pulse; the next start_i after reset SHALL begin a clean job.
REQ-023 Reset SHALL take priority over start_i in the same cycle.

Verification
REQ-024 Pair the block with a 1-cycle-latency RAM model (mem[i]=i); base=0x10, len=4, ready_i=1 -> data 0x10,0x11,0x12,0x13 on consecutive cycles, first valid 2 cycles after start, done_o pulse on the 4th accept.
REQ-025 RAM_WORDS_SIZE=256, base=0xFE, len=4 -> data 0xFE,0xFF,0x00,0x01, then done_o.
REQ-026 base=0, len=8, ready_i toggling 1,0,0,1,0,1... -> all 8 words in order, no duplicates, data_o stable while stalled, FIFO never exceeds 2 entries.
REQ-027 len=0 start -> done_o pulse the next cycle; busy_o and valid_o stay 0; no reads issued.
REQ-028 rst_i asserted after 2 of 6 words accepted -> outputs zero the next cycle and no done_o; a new start base=0x40, len=2 -> 0x40, 0x41, done_o.
REQ-029 start_i pulsed during busy with different base -> ignored; the original job completes unchanged.
